// File: rtl/fx_add_pkg.sv
// Shared types, width helpers and saturation constants
// for the shared fixed-point adder scheduler.
package fx_add_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_INT_W  = 4;
  localparam int DEF_FRAC_W = 5;

  function automatic int calc_w(
    input int int_w,
    input int frac_w
  );
    return int_w + frac_w;
  endfunction

  function automatic int id_w(
    input int nreq
  );
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  localparam int FX_W    = calc_w(DEF_INT_W, DEF_FRAC_W);
  localparam int FX_ID_W = id_w(DEF_NREQ);

  localparam logic [FX_W-1:0] SAT_MAX =
    {1'b0, {(FX_W-1){1'b1}}};
  localparam logic [FX_W-1:0] SAT_MIN =
    {1'b1, {(FX_W-1){1'b0}}};

  typedef struct packed {
    logic [FX_ID_W-1:0] id;
    logic [FX_W-1:0]    sum;
    logic               ovf;
  } fx_res_t;

endpackage

// File: rtl/fx_sat_add_pipe.sv
// Saturating signed adder, ADD_LAT register stages,
// carrying the requester tag and a valid bit alongside.
module fx_sat_add_pipe
  import fx_add_pkg::*;
#(
  parameter int W       = FX_W,
  parameter int IDW     = FX_ID_W,
  parameter int ADD_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [W-1:0]   out_sum,
  output logic           out_ovf
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           ovf;
  } stg_t;

  localparam logic [W-1:0] SMAX =
    {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN =
    {1'b1, {(W-1){1'b0}}};

  logic [W:0]         ext;
  stg_t               s0;
  logic [ADD_LAT-1:0] v_q;
  stg_t               d_q [ADD_LAT];

  // One guard bit: a disagreement between the top two
  // bits of the widened sum means the format overflowed.
  always_comb begin
    ext = {in_a[W-1], in_a} + {in_b[W-1], in_b};
    s0.id  = in_id;
    s0.sum = ext[W-1:0];
    s0.ovf = 1'b0;
    if (ext[W] != ext[W-1]) begin
      s0.ovf = 1'b1;
      s0.sum = ext[W] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      for (int i = 1; i < ADD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    d_q[0] <= s0;
    for (int i = 1; i < ADD_LAT; i++) begin
      d_q[i] <= d_q[i-1];
    end
  end

  assign out_valid = v_q[ADD_LAT-1];
  assign out_id    = d_q[ADD_LAT-1].id;
  assign out_sum   = d_q[ADD_LAT-1].sum;
  assign out_ovf   = d_q[ADD_LAT-1].ovf;

endmodule

// File: rtl/fx_add_sched.sv
// Round-robin scheduler sharing one saturating adder,
// with a credit-protected, tagged result FIFO.
module fx_add_sched
  import fx_add_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int INT_W      = 4,
  parameter  int FRAC_W     = 5,
  parameter  int ADD_LAT    = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int W          = calc_w(INT_W, FRAC_W),
  localparam int IDW        = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_sum,
  output logic              res_ovf,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           ovf;
  } res_t;

  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  infl_q;
  logic [CW-1:0]  cnt_n;
  logic [CW-1:0]  infl_n;
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic           busy_q;
  res_t           mem_q [FIFO_DEPTH];
  res_t           head;

  logic           found;
  logic [IDW-1:0] win;
  int             idx;
  logic           has_credit;
  logic           acc;
  logic           pop;

  logic           p_valid;
  logic [IDW-1:0] p_id;
  logic [W-1:0]   p_sum;
  logic           p_ovf;

  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid & res_ready;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // A same-cycle pop frees a slot, so it counts as credit.
  assign has_credit =
    (int'(cnt_q) + int'(infl_q)) <
    (FIFO_DEPTH + int'(pop));

  assign acc = found & has_credit & ~rst;

  always_comb begin
    req_ready = '0;
    if (acc) begin
      req_ready[win] = 1'b1;
    end
  end

  fx_sat_add_pipe #(
    .W       (W),
    .IDW     (IDW),
    .ADD_LAT (ADD_LAT)
  ) u_add (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc),
    .in_id     (win),
    .in_a      (req_a[win*W +: W]),
    .in_b      (req_b[win*W +: W]),
    .out_valid (p_valid),
    .out_id    (p_id),
    .out_sum   (p_sum),
    .out_ovf   (p_ovf)
  );

  always_comb begin
    cnt_n  = cnt_q + CW'(p_valid) - CW'(pop);
    infl_n = infl_q + CW'(acc) - CW'(p_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= IDW'(NREQ - 1);
      cnt_q  <= '0;
      infl_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      if (acc) begin
        ptr_q <= win;
      end
      if (p_valid) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q  <= cnt_n;
      infl_q <= infl_n;
      busy_q <= (infl_n != '0) | (cnt_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (p_valid) begin
      mem_q[wr_q] <= '{id: p_id, sum: p_sum, ovf: p_ovf};
    end
  end

  // Stale entries stay hidden behind an empty FIFO.
  assign head    = mem_q[rd_q];
  assign res_id  = res_valid ? head.id  : '0;
  assign res_sum = res_valid ? head.sum : '0;
  assign res_ovf = res_valid ? head.ovf : 1'b0;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fx_add_sched.sv
// Bench for fx_add_sched: vector table, scoreboard,
// round-robin, backpressure and mid-flight reset.
module tb_fx_add_sched;

  localparam int NREQ       = 4;
  localparam int INT_W      = 4;
  localparam int FRAC_W     = 5;
  localparam int ADD_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int W          = 9;
  localparam int IDW        = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_sum;
  logic              res_ovf;
  logic              busy;

  always #5 clk = ~clk;

  fx_add_sched #(
    .NREQ       (NREQ),
    .INT_W      (INT_W),
    .FRAC_W     (FRAC_W),
    .ADD_LAT    (ADD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           ovf;
  } exp_t;

  typedef struct {
    int         id;
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] sum;
    logic       ovf;
  } vec_t;

  exp_t       sb [$];
  int         grant_q [$];
  int         gcyc_q [$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         acc_total = 0;
  logic [8:0] exp_sum_r [NREQ];
  logic       exp_ovf_r [NREQ];
  logic [NREQ-1:0] acc_now = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  // Integer reference: exact sum clamped to the Q4.5 range.
  function automatic void model(input  logic [8:0] a,
                                input  logic [8:0] b,
                                output logic [8:0] s,
                                output logic       o);
    int t;
    t = int'($signed(a)) + int'($signed(b));
    if (t > 255) begin
      s = 9'h0FF; o = 1'b1;
    end else if (t < -256) begin
      s = 9'h100; o = 1'b1;
    end else begin
      s = t[8:0]; o = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    acc_now = '0;
    if (!rst) begin
      if (req_ready != '0)
        chk("ready_onehot", 32'($onehot(req_ready)), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_now[i] = 1'b1;
          sb.push_back('{id: 2'(i), sum: exp_sum_r[i],
                         ovf: exp_ovf_r[i]});
          grant_q.push_back(i);
          gcyc_q.push_back(cyc);
          acc_total++;
        end
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(res_id), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_sum", 32'(res_sum), 32'(e.sum));
          chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [8:0] a,
                        input logic [8:0] b,
                        input logic [8:0] es,
                        input logic eo);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    exp_sum_r[i] = es;
    exp_ovf_r[i] = eo;
    req_valid[i] = 1'b1;
  endtask

  task automatic set_rand(input int i);
    logic [8:0] a, b, s;
    logic o;
    a = 9'($urandom);
    b = 9'($urandom);
    model(a, b, s, o);
    set_op(i, a, b, s, o);
  endtask

  task automatic stream(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (acc_now[i]) set_rand(i);
    end
  endtask

  task automatic wait_accept(input int i);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_now[i] && n < 20);
    chk("accept_timeout", 32'(acc_now[i]), 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_drained"},
        32'(sb.size() == 0 && !busy), 1);
  endtask

  vec_t vt [11];
  int   base;
  int   lat;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{2, 9'h040, 9'h030, 9'h070, 1'b0};
    vt[1]  = '{0, 9'h0F0, 9'h020, 9'h0FF, 1'b1};
    vt[2]  = '{1, 9'h100, 9'h1E0, 9'h100, 1'b1};
    vt[3]  = '{3, 9'h1FF, 9'h001, 9'h000, 1'b0};
    vt[4]  = '{0, 9'h0FF, 9'h1FF, 9'h0FE, 1'b0};
    vt[5]  = '{1, 9'h0FF, 9'h0FF, 9'h0FF, 1'b1};
    vt[6]  = '{3, 9'h100, 9'h100, 9'h100, 1'b1};
    vt[7]  = '{3, 9'h080, 9'h080, 9'h0FF, 1'b1};
    vt[8]  = '{0, 9'h180, 9'h180, 9'h100, 1'b0};
    vt[9]  = '{1, 9'h07F, 9'h081, 9'h0FF, 1'b1};
    vt[10] = '{2, 9'h0AA, 9'h156, 9'h000, 1'b0};

    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      exp_sum_r[i] = '0;
      exp_ovf_r[i] = 1'b0;
    end
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    chk("rst_res_ovf", 32'(res_ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // single op with latency measurement
    set_op(2, 9'h040, 9'h030, 9'h070, 1'b0);
    wait_accept(2);
    lat = -1;
    for (int n = 0; n < 10 && lat < 0; n++) begin
      @(negedge clk);
      #1;
      if (res_valid) lat = cyc - gcyc_q[$];
    end
    chk("latency", 32'(lat), ADD_LAT + 1);
    drain("single");

    foreach (vt[k]) begin
      set_op(vt[k].id, vt[k].a, vt[k].b,
             vt[k].sum, vt[k].ovf);
      wait_accept(vt[k].id);
    end
    drain("table");

    // continuous round-robin, last grant was requester 2
    grant_q.delete();
    gcyc_q.delete();
    for (int i = 0; i < NREQ; i++) set_rand(i);
    stream(16);
    req_valid = '0;
    chk("rr_count", 32'(grant_q.size()), 16);
    chk("rr_first", 32'(grant_q[0]), 3);
    for (int k = 1; k < grant_q.size(); k++) begin
      chk("rr_order", 32'(grant_q[k]),
          32'((grant_q[k-1] + 1) % NREQ));
      chk("rr_gap", 32'(gcyc_q[k] - gcyc_q[k-1]), 1);
    end
    drain("rr");

    // backpressure: only FIFO_DEPTH credits
    res_ready = 1'b0;
    base = acc_total;
    for (int i = 0; i < NREQ; i++) set_rand(i);
    stream(12);
    chk("bp_accepts", 32'(acc_total - base), FIFO_DEPTH);
    chk("bp_ready_zero", 32'(req_ready), 0);
    res_ready = 1'b1;
    stream(1);
    res_ready = 1'b0;
    stream(8);
    chk("bp_one_more", 32'(acc_total - base),
        FIFO_DEPTH + 1);
    chk("bp_still_full", 32'(req_ready), 0);
    res_ready = 1'b1;
    stream(2);
    res_ready = 1'b0;
    stream(8);
    chk("bp_two_more", 32'(acc_total - base),
        FIFO_DEPTH + 3);
    req_valid = '0;
    res_ready = 1'b1;
    drain("bp");

    // reset with two queued and two in flight
    res_ready = 1'b0;
    base = acc_total;
    for (int i = 0; i < NREQ; i++) set_rand(i);
    for (int n = 0; n < 12 && acc_total - base < 4; n++)
      stream(1);
    chk("pre_rst_accepts", 32'(acc_total - base), 4);
    chk("pre_rst_valid", 32'(res_valid), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_res_sum", 32'(res_sum), 0);
    chk("mid_rst_res_id", 32'(res_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_res_valid", 32'(res_valid), 0);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    grant_q.delete();
    res_ready = 1'b1;
    stream(3);
    req_valid = '0;
    chk("post_rst_first", 32'(grant_q[0]), 0);
    drain("post_rst");
    repeat (4) tick();
    chk("end_res_valid", 32'(res_valid), 0);
    chk("end_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fx_add_sched.md
Name: fx_add_sched

Overview:
- Round-robin scheduler that shares one pipelined, saturating signed fixed-point adder among NREQ requesters.
- Each requester presents operands with a valid/ready handshake.
- The scheduler grants one requester per cycle and feeds the shared adder core.
- Results, tagged with the requester ID, are returned through a credit-protected result FIFO with valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- INT_W, 4, integer bits of operands and result, sign bit included.
- FRAC_W, 5, fractional bits of operands and result.
- ADD_LAT, 2, adder pipeline latency in cycles (>=1).
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  one-hot grant/accept; a transfer occurs on req_valid[i]&req_ready[i].
- req_a  in  NREQ*W  packed operand A, W=INT_W+FRAC_W, signed two's complement, requester i at [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same format.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head.
- res_id  out  clog2(NREQ)  requester index of head result.
- res_sum  out  W  saturated sum, same Q(INT_W.FRAC_W) format.
- res_ovf  out  1  saturation occurred for head result.
- busy  out  1  any operation in flight or FIFO non-empty.

Behaviour:
- Reset (async assert, sync-safe release):
  - req_ready=0, res_valid=0, res_id=0, res_sum=0, res_ovf=0, busy=0.
  - RR pointer=NREQ-1, so requester 0 has first priority.
  - FIFO pointers, in-flight count and pipeline valids all cleared.
  - Reset mid-operation discards all in-flight and queued results; nothing is replayed.
- Credit: credit = FIFO_DEPTH - fifo_count - inflight.
  - A grant is allowed only when credit>0, counting a same-cycle FIFO pop.
  - The FIFO therefore never overflows and the adder pipeline never stalls.
- Arbitration (combinational from registered state and req_valid):
  - Search from ptr+1 modulo NREQ; the first asserted req_valid wins.
  - req_ready[winner]=1 only if credit>0; otherwise all req_ready=0.
  - On a transfer, ptr<=winner.
  - A requester may hold req_valid across cycles; operands must stay stable until accepted.
- Adder (sub-module):
  - Sign-extend both operands to W+1 bits and add.
  - If bits [W] and [W-1] of the sum differ: saturate to +max (0 followed by ones) when bit W=0, or to -min (1 followed by zeros) when bit W=1, and set ovf=1.
  - Otherwise output sum[W-1:0] with ovf=0.
  - Result, tag and ovf emerge exactly ADD_LAT cycles after acceptance, with a valid bit carried alongside.
- Latency: accept in cycle T -> FIFO write at end of T+ADD_LAT -> res_valid=1 in T+ADD_LAT+1 if the FIFO was empty. Throughput is 1 op/cycle when res_ready=1.
- FIFO:
  - Pop on res_valid&res_ready.
  - Simultaneous push and pop keeps the count unchanged; push into an empty FIFO is visible the next cycle, with no fall-through.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- In-flight count: +1 on accept, -1 on pipeline exit; both events in the same cycle leave it unchanged.
- busy = (inflight!=0) | (fifo_count!=0), registered.
- Ordering: results leave in acceptance order.

Decomposition:
- Package fx_add_pkg holds:
  - W calculation function.
  - clog2-based ID width function.
  - Saturation constants SAT_MAX/SAT_MIN, computed from INT_W/FRAC_W.
  - Result record typedef {id, sum, ovf}.
- Sub-module fx_sat_add_pipe: the parameterised ADD_LAT saturating adder, carrying the tag and valid bit through the pipeline. Arbiter, credit counter and FIFO stay in fx_add_sched.

Test Plan:
- Single op, requester 2: a=0x040 (2.0), b=0x030 (1.5), res_ready=1 -> res_valid exactly ADD_LAT+1 cycles after accept; res_id=2, res_sum=0x070, res_ovf=0.
- Positive overflow: a=0x0F0 (7.5) + b=0x020 (1.0) -> res_sum=0x0FF (+7.96875), res_ovf=1. Negative overflow: a=0x100 (-8.0) + b=0x1E0 (-1.0) -> res_sum=0x100, res_ovf=1.
- All four requesters valid continuously, res_ready=1 -> grants in order 0,1,2,3,0,...; one accept per cycle; res_id sequence matches grant order.
- res_ready=0 with continuous requests -> exactly FIFO_DEPTH accepts (4), then req_ready all 0. Raising res_ready for one cycle -> one more accept; no result lost or duplicated.
- Assert rst while 2 ops are in flight and 2 results are queued -> outputs go to 0 immediately. After release: busy=0, no stale res_valid, and requester 0 is granted first.
- Simultaneous push and pop at FIFO full with one op in flight -> count stays at depth, no overflow, credit stays 0 until the pop completes.
